// File: rtl/iir_sample_scheduler.sv
// Paces single samples through an AXI-Stream IIR filter at a fixed tick rate,
// with result timeout, held-valid output and overrun/timeout status.
module iir_sample_scheduler #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CLK_DIV        = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         clear_status,
    input  logic signed [DATA_WIDTH-1:0] adc_tdata,
    input  logic                         adc_tvalid,
    output logic signed [DATA_WIDTH-1:0] flt_s_axis_tdata,
    output logic                         flt_s_axis_tvalid,
    input  logic                         flt_s_axis_tready,
    input  logic signed [DATA_WIDTH-1:0] flt_m_axis_tdata,
    input  logic                         flt_m_axis_tvalid,
    output logic                         flt_m_axis_tready,
    output logic signed [DATA_WIDTH-1:0] out_tdata,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         overrun_cnt,
    output logic                         timeout_err
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        ISSUE,
        WAIT_RESULT,
        DELIVER
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [DIV_W-1:0]               tick_cnt;
    logic [TO_W-1:0]                to_cnt;
    logic [TO_W-1:0]                to_cnt_nxt;
    logic signed [DATA_WIDTH-1:0]   hold;
    logic signed [DATA_WIDTH-1:0]   s_data_nxt;
    logic signed [DATA_WIDTH-1:0]   o_data_nxt;
    logic                           tick_c;
    logic                           drop_c;
    logic                           timeout_c;

    assign tick_c = enable && (tick_cnt == DIV_LAST);
    // A tick is only consumed in WAIT_TICK; any other state drops it.
    assign drop_c = tick_c && (state != WAIT_TICK);

    // Sample-rate divider; parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!enable || tick_cnt == DIV_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // Most recent ADC sample, captured in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (adc_tvalid) begin
            hold <= adc_tdata;
        end
    end

    // Next-state, timeout and data-path decisions.
    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        s_data_nxt = flt_s_axis_tdata;
        o_data_nxt = out_tdata;
        timeout_c  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (tick_c) begin
                    state_nxt  = ISSUE;
                    s_data_nxt = hold;
                end
            end
            ISSUE: begin
                if (flt_s_axis_tready) begin
                    state_nxt  = WAIT_RESULT;
                    to_cnt_nxt = '0;
                end
            end
            WAIT_RESULT: begin
                if (flt_m_axis_tvalid) begin
                    o_data_nxt = flt_m_axis_tdata;
                    state_nxt  = DELIVER;
                end else if (to_cnt == TO_LAST) begin
                    timeout_c = 1'b1;
                    state_nxt = enable ? WAIT_TICK : IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            DELIVER: begin
                if (out_tready) state_nxt = enable ? WAIT_TICK : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State plus registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            to_cnt            <= '0;
            flt_s_axis_tdata  <= '0;
            flt_s_axis_tvalid <= 1'b0;
            flt_m_axis_tready <= 1'b0;
            out_tdata         <= '0;
            out_tvalid        <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nxt;
            to_cnt            <= to_cnt_nxt;
            flt_s_axis_tdata  <= s_data_nxt;
            flt_s_axis_tvalid <= (state_nxt == ISSUE);
            flt_m_axis_tready <= (state_nxt == WAIT_RESULT);
            out_tdata         <= o_data_nxt;
            out_tvalid        <= (state_nxt == DELIVER);
            busy              <= (state_nxt == ISSUE) || (state_nxt == WAIT_RESULT) ||
                                 (state_nxt == DELIVER);
        end
    end

    // Status; a clear request overrides a same-cycle increment or set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else if (clear_status) begin
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (drop_c && overrun_cnt != CNT_MAX) overrun_cnt <= overrun_cnt + CNT_WIDTH'(1);
            if (timeout_c) timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/iir_sample_scheduler.md
Name: iir_sample_scheduler

Overview:
Sequences one sample at a time through the AXI-Stream IIR filter (e.g. the 4th-order bandpass) at a fixed sample rate derived from the system clock. It latches the most recent ADC sample and issues it to the filter on each sample tick, then waits for the filter result with a timeout and delivers it on a held-valid output stream. It also counts overruns and flags timeouts. It sits between the ADC capture logic and downstream consumers, replacing ad-hoc testbench pacing of s_axis_tvalid.

Parameters:
DATA_WIDTH, 16, sample width, signed, for ADC, filter and output data
CLK_DIV, 100000, clock cycles per sample tick (50 MHz / 500 Hz); minimum 4
TIMEOUT_CYCLES, 1024, maximum cycles to wait for a filter result after issue
CNT_WIDTH, 16, width of the saturating overrun counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
enable  in  1  run scheduler
clear_status  in  1  one-cycle pulse; clears overrun_cnt and timeout_err
adc_tdata  in  DATA_WIDTH  ADC sample
adc_tvalid  in  1  ADC sample strobe; always accepted
flt_s_axis_tdata  out  DATA_WIDTH  sample to filter
flt_s_axis_tvalid  out  1  sample valid to filter
flt_s_axis_tready  in  1  filter ready
flt_m_axis_tdata  in  DATA_WIDTH  filter result
flt_m_axis_tvalid  in  1  filter result valid
flt_m_axis_tready  out  1  scheduler ready for result
out_tdata  out  DATA_WIDTH  filtered sample
out_tvalid  out  1  output valid; held until accepted
out_tready  in  1  downstream ready
busy  out  1  high in any state except IDLE and WAIT_TICK
overrun_cnt  out  CNT_WIDTH  saturating count of dropped ticks
timeout_err  out  1  sticky; set on filter timeout

Behaviour:
- Reset state: all outputs 0. The FSM is in IDLE. The tick counter, hold register and timeout counter are 0.
- Hold register: on every cycle with adc_tvalid=1, hold <= adc_tdata, regardless of state. On a tick, the current hold value is issued. A stale hold value is reissued without error.
- Tick counter: counts 0..CLK_DIV-1 while enable=1 and wraps to 0. tick=1 in the cycle where count==CLK_DIV-1. When enable=0, the counter is forced to 0 on the next edge.
- FSM states: IDLE, WAIT_TICK, ISSUE, WAIT_RESULT, DELIVER.
  - IDLE: enable=1 -> WAIT_TICK.
  - WAIT_TICK: if enable=0 -> IDLE; else if tick -> ISSUE, and flt_s_axis_tdata <= hold.
  - ISSUE: flt_s_axis_tvalid=1 with tdata stable. When flt_s_axis_tready=1 at the edge -> WAIT_RESULT, and the timeout counter clears.
  - WAIT_RESULT: flt_m_axis_tready=1 (only in this state).
    - If flt_m_axis_tvalid=1: out_tdata <= flt_m_axis_tdata, -> DELIVER.
    - Else the timeout counter increments. When it reaches TIMEOUT_CYCLES-1 with no result: timeout_err <= 1, -> WAIT_TICK (or IDLE if enable=0), and no output is produced.
  - DELIVER: out_tvalid=1 with data stable until out_tready=1 at the edge, then -> WAIT_TICK (or IDLE if enable=0).
- Latency: a tick at edge T gives flt_s_axis_tvalid=1 in cycle T+1. With tready=1 it is a single-cycle pulse. out_tvalid asserts one cycle after the result handshake.
- Overrun: a tick occurring while the state is not WAIT_TICK is dropped and overrun_cnt increments, saturating at 2^CNT_WIDTH-1. This applies even in the cycle the FSM returns to WAIT_TICK.
- clear_status: clears overrun_cnt and timeout_err. If it coincides with an increment or set event, clear wins.
- enable dropped mid-transaction: the current transaction completes, including DELIVER. The FSM then goes to IDLE, and no new tick is accepted.
- Filter result arriving outside WAIT_RESULT: not accepted (tready=0) and not an error.
- Reset mid-operation: immediate abandonment. All outputs return to reset values asynchronously. A pending output sample is lost.

Test Plan:
1. CLK_DIV=10, enable=1, hold=32767, filter model returns data+1 after 3 cycles, out_tready=1 -> flt_s_axis_tvalid one-cycle pulse every 10 cycles; first pulse 10 cycles after enable; out_tdata=-32768 (wrap); overrun_cnt=0.
2. Filter model holds flt_s_axis_tready=0 for 5 cycles -> flt_s_axis_tvalid stays high 6 cycles with tdata constant; exactly one result is delivered.
3. Filter never returns a result, TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 cycles in WAIT_RESULT; out_tvalid never asserts; the next tick is issued normally.
4. out_tready=0 for 25 cycles with CLK_DIV=10 -> out_tvalid and out_tdata held stable; overrun_cnt=2; clear_status pulse coinciding with a third tick -> overrun_cnt=0.
5. Deassert enable during WAIT_RESULT -> the result is still delivered, then the FSM goes to IDLE; no further flt_s_axis_tvalid; the tick counter reads 0.
6. Assert rst_n=0 during DELIVER -> out_tvalid, busy and flt_m_axis_tready are 0 immediately, without waiting for a clock edge; after release with enable=1, the first issue occurs CLK_DIV cycles later with hold=0.
